// File: rtl/shift_sequencer_pkg.sv
// Shared constants and types for the iterative barrel-shift sequencer.
// Holds the operand/shift-amount widths, shift-code values, FSM encodings and clamp limits.
// Imported by shift_sequencer and shift_step; no logic lives here.
package shift_sequencer_pkg;

    localparam int SHIFTCODEW = 2;
    localparam int FULLW_DEF  = 32;
    localparam int WIDTH_DEF  = 8;

    // Remaining-count register must hold the largest effective count (33).
    localparam int CNTW = 6;
    // ROR reduces the amount modulo 32, i.e. keeps the low 5 bits.
    localparam int ROTW = 5;

    // Saturation limits for register-specified shift amounts.
    localparam int unsigned CLAMP_ASR  = 32;
    localparam int unsigned CLAMP_LONG = 33;

    typedef enum logic [SHIFTCODEW-1:0] {
        SC_LSL = 2'd0,
        SC_LSR = 2'd1,
        SC_ASR = 2'd2,
        SC_ROR = 2'd3
    } shift_code_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational shift step: 1 bit, or 4 bits when step4 is set (SHIFTSEQ_FAST4_EN builds only).
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the step result is registered.
// Ports: value_in/code/carry_in -> value_out/carry_out (carry = last bit shifted out).
module shift_step
    import shift_sequencer_pkg::*;
#(
    parameter int FULLW = FULLW_DEF
) (
    input  logic [FULLW-1:0] value_in,
    input  shift_code_e      code,
    input  logic             carry_in,
`ifdef SHIFTSEQ_FAST4_EN
    input  logic             step4,
`endif
    output logic [FULLW-1:0] value_out,
    output logic             carry_out
);

    // One-bit step; returns {carry, value}.
    function automatic logic [FULLW:0] step1(input logic [FULLW-1:0] v,
                                             input shift_code_e      c,
                                             input logic             ci);
        case (c)
            SC_LSL:  step1 = {v, 1'b0};
            SC_LSR:  step1 = {v[0], 1'b0, v[FULLW-1:1]};
            SC_ASR:  step1 = {v[0], v[FULLW-1], v[FULLW-1:1]};
            SC_ROR:  step1 = {v[0], v[0], v[FULLW-1:1]};
            // Unreachable encodings leave value and carry untouched.
            default: step1 = {ci, v};
        endcase
    endfunction

    logic [FULLW:0] acc;

    always_comb begin
        acc = step1(value_in, code, carry_in);
`ifdef SHIFTSEQ_FAST4_EN
        if (step4) begin
            for (int i = 1; i < 4; i++) begin
                acc = step1(acc[FULLW-1:0], code, acc[FULLW]);
            end
        end
`endif
        carry_out = acc[FULLW];
        value_out = acc[FULLW-1:0];
    end

endmodule

// File: rtl/shift_sequencer.sv
// Iterative ARM-style register-specified shifter (LSL/LSR/ASR/ROR) with carry-out.
// Latency: N+1 cycles from the accept cycle (N = effective count); SHIFTSEQ_FAST4_EN: floor(N/4)+(N mod 4)+1.
// Backpressure: valid/ready both sides; one request in flight, result held in DONE until out_ready.
// Ports: clk, rst_n (async active-low), flush; in_valid/in_ready/operand/shiftcode/shiftby/carry_in;
//        out_valid/out_ready/result/carry_out; busy. Macro SHIFTSEQ_FAST4_EN enables 4-bit steps.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int FULLW = FULLW_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FULLW-1:0]      operand,
    input  logic [SHIFTCODEW-1:0] shiftcode,
    input  logic [WIDTH-1:0]      shiftby,
    input  logic                  carry_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FULLW-1:0]      result,
    output logic                  carry_out,
    output logic                  busy
);

    localparam logic [WIDTH-1:0] LIM_LONG_W = WIDTH'(CLAMP_LONG);
    localparam logic [WIDTH-1:0] LIM_ASR_W  = WIDTH'(CLAMP_ASR);

    state_e            state;
    shift_code_e       code_q;
    logic [CNTW-1:0]   cnt_q;
    logic [FULLW-1:0]  val_q;
    logic              c_q;

    logic [CNTW-1:0]   n_eff;
    logic [CNTW-1:0]   step_amt;
    logic [FULLW-1:0]  step_val;
    logic              step_c;

    // Effective count: saturate LSL/LSR/ASR, fold ROR into 1..32.
    always_comb begin
        n_eff = '0;
        case (shift_code_e'(shiftcode))
            SC_LSL, SC_LSR: n_eff = (shiftby > LIM_LONG_W) ? CNTW'(CLAMP_LONG) : shiftby[CNTW-1:0];
            SC_ASR:         n_eff = (shiftby > LIM_ASR_W)  ? CNTW'(CLAMP_ASR)  : shiftby[CNTW-1:0];
            SC_ROR: begin
                if (shiftby == '0)
                    n_eff = '0;
                else if (shiftby[ROTW-1:0] == '0)
                    n_eff = CNTW'(CLAMP_ASR);
                else
                    n_eff = CNTW'(shiftby[ROTW-1:0]);
            end
            default:        n_eff = '0;
        endcase
    end

`ifdef SHIFTSEQ_FAST4_EN
    logic step4;
    assign step4    = (cnt_q >= CNTW'(4));
    assign step_amt = step4 ? CNTW'(4) : CNTW'(1);
`else
    assign step_amt = CNTW'(1);
`endif

    shift_step #(.FULLW(FULLW)) u_step (
        .value_in  (val_q),
        .code      (code_q),
        .carry_in  (c_q),
`ifdef SHIFTSEQ_FAST4_EN
        .step4     (step4),
`endif
        .value_out (step_val),
        .carry_out (step_c)
    );

    // Reset gates in_ready so nothing is accepted while rst_n is low.
    assign in_ready  = rst_n && (state == ST_IDLE) && !flush;
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign result    = val_q;
    assign carry_out = c_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            code_q <= SC_LSL;
            cnt_q  <= '0;
            val_q  <= '0;
            c_q    <= 1'b0;
        end else if (flush) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        val_q  <= operand;
                        code_q <= shift_code_e'(shiftcode);
                        c_q    <= carry_in;
                        cnt_q  <= n_eff;
                        state  <= (n_eff == '0) ? ST_DONE : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    val_q <= step_val;
                    c_q   <= step_c;
                    cnt_q <= cnt_q - step_amt;
                    if (cnt_q == step_amt)
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Testbench for shift_sequencer: directed boundary cases, flush/reset aborts and randomized requests.
// Latency: checks out_valid timing against the effective-count rule for the build under test.
// Backpressure: exercises out_ready held low in DONE and back-to-back requests.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] operand;
    logic [1:0]  shiftcode;
    logic [7:0]  shiftby;
    logic        carry_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        carry_out;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shift_sequencer #(.FULLW(32), .WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operand   (operand),
        .shiftcode (shiftcode),
        .shiftby   (shiftby),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: shift as arithmetic on a 64-bit window; carry is the bit just past the result.
    function automatic logic [32:0] ref_shift(input logic [31:0] op, input logic [1:0] code,
                                              input int by, input logic cin);
        logic [63:0] t;
        logic [31:0] res;
        int          r;
        if (by == 0) return {cin, op};
        case (code)
            2'd0: begin t = {32'b0, op} << by; return {t[32], t[31:0]}; end
            2'd1: begin t = {op, 32'b0} >> by; return {t[31], t[63:32]}; end
            2'd2: begin t = $signed({op, 32'b0}) >>> by; return {t[31], t[63:32]}; end
            default: begin
                r   = by % 32;
                res = (r == 0) ? op : ((op >> r) | (op << (32 - r)));
                return {res[31], res};
            end
        endcase
    endfunction

    function automatic int eff_n(input logic [1:0] code, input int by);
        case (code)
            2'd0, 2'd1: return (by > 33) ? 33 : by;
            2'd2:       return (by > 32) ? 32 : by;
            default:    return (by == 0) ? 0 : ((by - 1) % 32) + 1;
        endcase
    endfunction

    function automatic int exp_cycles(input int n);
`ifdef SHIFTSEQ_FAST4_EN
        return n / 4 + n % 4;
`else
        return n;
`endif
    endfunction

    // Called at posedge+1 with the DUT idle. Issues one request, checks latency, result,
    // stability while out_ready is held low for 'hold' cycles, then releases the result.
    task automatic do_req(input string tag, input logic [31:0] op, input logic [1:0] code,
                          input logic [7:0] by, input logic cin, input int hold);
        logic [32:0] exp;
        int          k;
        exp = ref_shift(op, code, int'(by), cin);
        in_valid  = 1'b1;
        operand   = op;
        shiftcode = code;
        shiftby   = by;
        carry_in  = cin;
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        operand  = $urandom;
        k = 1;
        while (!out_valid && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        chk({tag, ".latency"}, 64'(k), 64'(exp_cycles(eff_n(code, int'(by))) + 1));
        chk({tag, ".result"}, 64'(result), 64'(exp[31:0]));
        chk({tag, ".carry"}, 64'(carry_out), 64'(exp[32]));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, ".hold_valid"}, 64'({out_valid, in_ready}), 64'(2'b10));
            chk({tag, ".hold_data"}, 64'({carry_out, result}), 64'(exp));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".release"}, 64'({busy, out_valid}), 64'(2'b00));
    endtask

    // Counts out_valid pulses over a window; used after aborts.
    task automatic no_output(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk({tag, ".no_out_valid"}, 64'(seen), 64'(0));
        chk({tag, ".idle"}, 64'({busy, in_ready}), 64'(2'b01));
    endtask

    initial begin
        logic [1:0] rc;
        logic [7:0] rb;
        int         sel;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        operand = '0; shiftcode = '0; shiftby = '0; carry_in = 1'b0;

        // Reset state
        #12;
        chk("rst.in_ready", 64'(in_ready), 64'(0));
        chk("rst.busy_valid", 64'({busy, out_valid}), 64'(2'b00));
        chk("rst.result", 64'({carry_out, result}), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rst.in_ready_after", 64'(in_ready), 64'(1));

        // Directed vectors
        do_req("lsl1",     32'h8000_0001, 2'd0, 8'd1,   1'b0, 0);
        do_req("lsr32",    32'h8000_0000, 2'd1, 8'd32,  1'b0, 0);
        do_req("lsr200",   32'h8000_0000, 2'd1, 8'd200, 1'b1, 0);
        do_req("lsl32",    32'h0000_0001, 2'd0, 8'd32,  1'b0, 0);
        do_req("lsl33",    32'hFFFF_FFFF, 2'd0, 8'd33,  1'b1, 0);
        do_req("asr40",    32'h8000_0000, 2'd2, 8'd40,  1'b0, 0);
        do_req("asr32pos", 32'h7FFF_FFFF, 2'd2, 8'd32,  1'b1, 0);
        do_req("ror32",    32'h1234_5678, 2'd3, 8'd32,  1'b1, 0);
        do_req("ror4",     32'h1234_5678, 2'd3, 8'd4,   1'b0, 0);
        do_req("ror36",    32'h1234_5678, 2'd3, 8'd36,  1'b0, 0);
        do_req("zero",     32'hDEAD_BEEF, 2'd2, 8'd0,   1'b1, 0);

        // Result held while out_ready low, then immediate next request
        do_req("hold5",    32'hCAFE_F00D, 2'd1, 8'd7,   1'b0, 5);
        do_req("b2b",      32'h0F0F_0F0F, 2'd0, 8'd3,   1'b1, 0);

        // Flush in the 3rd SHIFT cycle
        in_valid = 1'b1; operand = 32'hA5A5_A5A5; shiftcode = 2'd0; shiftby = 8'd20; carry_in = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("flush3.busy_before", 64'(busy), 64'(1));
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        no_output("flush3", 40);
        do_req("after_flush", 32'h0000_00F0, 2'd1, 8'd4, 1'b0, 0);

        // Reset mid-shift
        in_valid = 1'b1; operand = 32'h1357_9BDF; shiftcode = 2'd3; shiftby = 8'd30; carry_in = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rstmid.state", 64'({busy, out_valid, in_ready}), 64'(3'b000));
        chk("rstmid.data", 64'({carry_out, result}), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        no_output("rstmid", 40);

        // Flush concurrent with in_valid: nothing accepted
        in_valid = 1'b1; flush = 1'b1; operand = 32'h1; shiftcode = 2'd0; shiftby = 8'd1;
        #1;
        chk("flushreq.in_ready", 64'(in_ready), 64'(0));
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        no_output("flushreq", 5);

        // Randomized requests with boundary-biased amounts
        for (int t = 0; t < 60; t++) begin
            rc  = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 6);
            case (sel)
                0: rb = 8'd0;
                1: rb = 8'd1;
                2: rb = 8'd31;
                3: rb = 8'd32;
                4: rb = 8'd33;
                5: rb = 8'd64;
                default: rb = 8'($urandom_range(0, 255));
            endcase
            do_req("rand", $urandom, rc, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter FULLW, default 32, operand and result width.
REQ-002 Parameter WIDTH, default 8, shift-amount width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 flush  in  1  synchronous abort of any in-flight shift.
REQ-006 in_valid  in  1  request present.
REQ-007 in_ready  out  1  request accepted when in_valid && in_ready.
REQ-008 operand  in  FULLW  value to shift.
REQ-009 shiftcode  in  SHIFTCODEW  LSL, LSR, ASR or ROR.
REQ-010 shiftby  in  WIDTH  shift amount, 0..255, register-specified semantics.
REQ-011 carry_in  in  1  CPSR C flag at request time.
REQ-012 out_valid  out  1  result available.
REQ-013 out_ready  in  1  consumer takes the result when out_valid && out_ready.
REQ-014 result  out  FULLW  shifted value.
REQ-015 carry_out  out  1  shifter carry-out.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 FSM states: IDLE, SHIFT, DONE.
- IDLE -> SHIFT on accept with an effective count N > 0.
- IDLE -> DONE on accept with N = 0.
- SHIFT -> DONE when the remaining count reaches 0.
- DONE -> IDLE on out_ready.
REQ-018 in_ready SHALL equal (state == IDLE) && !flush.
REQ-019 On accept, the block SHALL latch operand, shiftcode and carry_in, and load the remaining count with N.
REQ-020 Effective count N:
- LSL/LSR: min(shiftby, 33).
- ASR: min(shiftby, 32).
- ROR: 0 if shiftby == 0, else ((shiftby-1) mod 32) + 1.
REQ-021 Each SHIFT cycle, the block SHALL shift the working value by 1 bit and set the working carry to the last bit shifted out.
- LSL and LSR fill with 0.
- ASR fills with bit FULLW-1.
- ROR fills with the bit shifted out.
REQ-022 N = 0: result SHALL equal operand and carry_out SHALL equal carry_in.
REQ-023 Resulting boundary values:
- LSL/LSR by 32: result 0, carry = bit0 (LSL) or bit31 (LSR).
- LSL/LSR by 33 or more: result 0, carry 0.
- ASR by 32 or more: all bits and carry = sign bit.
- ROR by a nonzero multiple of 32: result = operand, carry = bit31.
REQ-024 Latency: out_valid SHALL assert on the edge N+1 cycles after the accept edge (1 cycle when N = 0).
REQ-025 In DONE, result and carry_out SHALL be held stable until out_ready; outputs are undefined outside DONE.
REQ-026 out_valid SHALL be high only in DONE.
REQ-027 flush SHALL force IDLE on the next edge from any state, discard any held result, and block acceptance in the same cycle.

Reset
REQ-028 While rst_n is low:
- state = IDLE, busy = 0, out_valid = 0;
- result, carry_out and the remaining count = 0;
- in_ready = 0.
REQ-029 Reset asserted mid-shift SHALL abandon the operation with no output.

Configuration
REQ-030 Macro SHIFTSEQ_FAST4_EN.
- Defined: each SHIFT cycle consumes 4 bits while the remaining count is 4 or more, else 1 bit; cycle count = floor(N/4) + (N mod 4); carry = last bit out.
- Undefined: 1 bit per cycle only.
- Results SHALL be identical in both builds.

Structure
REQ-031 defines.v SHALL hold the shared constants:
- SHIFTCODEW, FULLW, WIDTH;
- shift-code values LSL=0, LSR=1, ASR=2, ROR=3;
- FSM state encodings;
- clamp limits 32 and 33.
REQ-032 Single sub-module shift_step: combinational step of 1 (or 4 under SHIFTSEQ_FAST4_EN), taking value, code and carry, returning value and carry.

Verification
REQ-033 LSL 0x80000001 by 1, carry_in 0:
- result 0x00000002, carry 1;
- out_valid 2 cycles after accept.
REQ-034 LSR 0x80000000 by 32 -> result 0, carry 1. LSR by 200 -> result 0, carry 0, N = 33.
REQ-035 ASR 0x80000000 by 40 -> 0xFFFFFFFF, carry 1. ROR 0x12345678 by 32 -> 0x12345678, carry 0. ROR 0x12345678 by 4 -> 0x81234567, carry 1.
REQ-036 shiftby 0, carry_in 1 -> result = operand, carry 1, out_valid after 1 cycle.
REQ-037 out_ready held low 5 cycles in DONE -> result stable, in_ready 0. Then out_ready=1 -> IDLE; next request accepted the following cycle.
REQ-038 Each of the following SHALL give IDLE with no out_valid:
- flush in the 3rd SHIFT cycle;
- rst_n low mid-shift;
- flush concurrent with in_valid (no accept).
